// File: rtl/clk_fwd_enable_ctrl.sv
// Forwarded-clock enable controller: qualifies the asynchronous PLL/MMCM locked flag,
// settles before enabling the output stage, holds off after a loss and tracks loss status.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | forwarding not requested, enable low
// WAIT_LOCK | forwarding requested, waiting for synchronised lock
// SETTLE    | lock seen, counting SETTLE_CYCLES of stable lock
// RUN       | enable high, watching for loss of lock or request drop
// HOLDOFF   | lock was lost in RUN, enable forced low for HOLDOFF_CYCLES
module clk_fwd_enable_ctrl #(
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int HOLDOFF_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       locked_async,
   input  logic       fwd_req,
   input  logic       clear_status,
   output logic       clk_fwd_en,
   output logic       lock_lost,
   output logic [7:0] loss_cnt,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   logic                   loss_evt;

   // Only place locked_async is sampled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async};
      end
   end

   assign lock_s   = sync_q[SYNC_STAGES-1];
   assign loss_evt = (state == RUN) && fwd_req && !lock_s;
   assign state_o  = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         clk_fwd_en <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               clk_fwd_en <= 1'b0;
               if (fwd_req) state <= WAIT_LOCK;
            end
            WAIT_LOCK: begin
               clk_fwd_en <= 1'b0;
               if (!fwd_req) begin
                  state <= IDLE;
               end else if (lock_s) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end
            end
            SETTLE: begin
               if (!fwd_req) begin
                  state <= IDLE;
               end else if (!lock_s) begin
                  state <= WAIT_LOCK;
               end else if (cnt == SETTLE_LAST) begin
                  state      <= RUN;
                  clk_fwd_en <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (!fwd_req) begin
                  state      <= IDLE;
                  clk_fwd_en <= 1'b0;
               end else if (!lock_s) begin
                  state      <= HOLDOFF;
                  cnt        <= '0;
                  clk_fwd_en <= 1'b0;
               end
            end
            HOLDOFF: begin
               clk_fwd_en <= 1'b0;
               if (cnt == HOLDOFF_LAST) begin
                  state <= fwd_req ? WAIT_LOCK : IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               clk_fwd_en <= 1'b0;
            end
         endcase
      end
   end

   // A loss on the same edge as a clear restarts the count at one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_lost <= 1'b0;
         loss_cnt  <= 8'd0;
      end else if (loss_evt) begin
         lock_lost <= 1'b1;
         if (clear_status)          loss_cnt <= 8'd1;
         else if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
      end else if (clear_status) begin
         lock_lost <= 1'b0;
         loss_cnt  <= 8'd0;
      end
   end

endmodule

// File: doc/clk_fwd_enable_ctrl.md
Name: clk_fwd_enable_ctrl

Overview:
Controller directly upstream of the differential forwarded-clock output stage.
- Qualifies the asynchronous MMCM/PLL locked flag and waits a settle period before driving the output stage's clock-enable input.
- Removes the enable immediately on loss of lock and holds it off for a fixed time before re-arming.
- Keeps sticky loss-of-lock status for slow control.

Parameters:
SYNC_STAGES, 2, flops in the locked synchroniser chain (>=2)
SETTLE_CYCLES, 1024, cycles lock must stay stable before the enable asserts (>=1)
HOLDOFF_CYCLES, 64, cycles the enable stays forced low after a loss of lock (>=1)
CNT_W, 16, settle/holdoff counter width; SETTLE_CYCLES and HOLDOFF_CYCLES must each be <= 2^CNT_W

Ports:
clk  input  1  system clock, the same clock that feeds the output stage
rst  input  1  asynchronous active-low reset
locked_async  input  1  MMCM/PLL locked flag, asynchronous to clk
fwd_req  input  1  request to forward the clock (synchronous to clk)
clear_status  input  1  one-cycle pulse; clears lock_lost and loss_cnt
clk_fwd_en  output  1  clock-enable to the output stage's DDR register CE
lock_lost  output  1  sticky flag: lock dropped while in RUN
loss_cnt  output  8  saturating count of lock losses in RUN
state_o  output  3  current FSM state encoding, for debug

Behaviour:
- Reset (rst=0, asynchronous)
  - Synchroniser flops clear to 0.
  - FSM enters IDLE; counter clears to 0.
  - clk_fwd_en=0, lock_lost=0, loss_cnt=0, state_o=IDLE.
- Synchroniser: lock_s is the output of a SYNC_STAGES-deep flop chain on locked_async. No other logic samples locked_async.
- FSM states and encodings: IDLE=0, WAIT_LOCK=1, SETTLE=2, RUN=3, HOLDOFF=4. All transitions occur on the clk rising edge.
  - IDLE: fwd_req=1 -> WAIT_LOCK.
  - WAIT_LOCK: fwd_req=0 -> IDLE; else lock_s=1 -> SETTLE, counter=0.
  - SETTLE: priority order is fwd_req=0 -> IDLE; then lock_s=0 -> WAIT_LOCK (not counted as a loss); then counter==SETTLE_CYCLES-1 -> RUN; else counter+1.
  - RUN: priority order is fwd_req=0 -> IDLE (not a loss); then lock_s=0 -> HOLDOFF, counter=0, lock_lost<=1, loss_cnt+1 saturating at 255.
  - HOLDOFF: counter==HOLDOFF_CYCLES-1 -> (fwd_req ? WAIT_LOCK : IDLE); else counter+1. lock_s and fwd_req are otherwise ignored.
  - Unused encodings 5-7 -> IDLE on the next edge.
- clk_fwd_en
  - Dedicated flop, never a combinational decode.
  - Set on the edge that enters RUN; cleared on the edge that leaves RUN.
  - It is therefore high exactly while state_o==RUN.
- Latency
  - Assertion: counting the first edge that samples locked_async=1 as edge 1, with fwd_req already high, clk_fwd_en rises at edge SYNC_STAGES+1+SETTLE_CYCLES.
  - Deassertion: clk_fwd_en falls SYNC_STAGES+1 edges after locked_async falls.
- Status
  - clear_status=1 clears lock_lost and loss_cnt on the next edge.
  - If clear_status and a loss event occur on the same edge, the loss wins: lock_lost=1, loss_cnt=1.
- Counter: holds its value in IDLE and WAIT_LOCK. It is only compared in SETTLE and HOLDOFF.
- Reset mid-RUN: clk_fwd_en drops asynchronously with rst. Status is lost.
- Glitches: a lock glitch shorter than one clk period may be missed by the synchroniser. This is accepted; the MMCM locked flag is quasi-static.

Test Plan:
- Parameters SYNC_STAGES=2, SETTLE_CYCLES=16, HOLDOFF_CYCLES=8. fwd_req=1; locked_async rises before edge 1 -> clk_fwd_en=0 through edge 18, =1 at edge 19, state_o=3.
- From RUN, drop locked_async before edge k -> clk_fwd_en=0 at edge k+2, state_o=4, lock_lost=1, loss_cnt=1. Keep locked low -> after 8 HOLDOFF cycles state_o=1. Relock -> clk_fwd_en high again 19 edges after relock.
- In SETTLE at counter=10, pulse locked low for 3 cycles -> state returns to WAIT_LOCK, loss_cnt unchanged, settle restarts from 0, clk_fwd_en never glitches high.
- In RUN, deassert fwd_req -> IDLE next edge, clk_fwd_en=0, lock_lost stays 0. Repeat 300 lock losses in RUN -> loss_cnt saturates at 255.
- Assert clear_status on the same edge as a RUN loss -> lock_lost=1, loss_cnt=1. Pulse clear_status alone -> both return to 0 next edge.
- Assert rst=0 mid-RUN between clock edges -> clk_fwd_en=0 immediately, state_o=0, loss_cnt=0. Release rst with locked high -> full settle sequence repeats.
